cosim_commit_streamer: RTL
==========================

COSIM_COMMIT_STREAMER -- requirements
Module: cosim_commit_streamer

Interface
REQ-001 SHALL have parameter NUM_CORES, default 1, number of RTL cores streaming retired instructions (1..16).
REQ-002 SHALL have parameter DEPTH, default 4, per-core FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter CW, default max(1,$clog2(NUM_CORES)), width of the core-id field.
REQ-004 SHALL have clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have arm_i  in  1  level; high once the Spike model has been set up and started.
REQ-007 SHALL have commit_valid_i  in  NUM_CORES  per-core retire strobe.
REQ-008 SHALL have commit_pc_i  in  NUM_CORES*64  per-core retired PC, core k at bits [64k+63:64k].
REQ-009 SHALL have commit_insn_i  in  NUM_CORES*32  per-core retired instruction word.
REQ-010 SHALL have commit_ready_o  out  NUM_CORES  per-core FIFO not full.
REQ-011 SHALL have chk_valid_o  out  1  checker record valid.
REQ-012 SHALL have chk_ready_i  in  1  checker accepts the record.
REQ-013 SHALL have chk_core_o  out  CW, chk_pc_o  out  64, chk_insn_o  out  32  record payload.
REQ-014 SHALL have chk_seq_o  out  64  global index of the presented record.
REQ-015 SHALL have overflow_o  out  NUM_CORES  sticky per-core drop flag.

Function
REQ-016 SHALL push core k's {pc,insn} into FIFO k when commit_valid_i[k] && commit_ready_o[k], regardless of arm_i.
REQ-017 SHALL drive commit_ready_o[k] = (count_k != DEPTH), computed from the registered count only; a pop in the same cycle does not make a full FIFO accept.
REQ-018 SHALL drop a commit presented while FIFO k is full and set overflow_o[k], which holds until reset.
REQ-019 SHALL implement the control FSM IDLE -> RUN when arm_i==1; RUN -> DRAIN when arm_i falls; DRAIN -> IDLE once the output register is empty. DRAIN completes only the record already in the output register; no new records load.
REQ-020 SHALL load the output register only in RUN, when the register is empty or is handshaking this cycle (chk_valid_o && chk_ready_i).
REQ-021 SHALL select the source FIFO round-robin among non-empty FIFOs, starting at the priority pointer; after a grant to core g, the pointer becomes (g+1) mod NUM_CORES.
REQ-022 SHALL pop the granted FIFO in the same cycle it loads the output register.
REQ-023 SHALL hold all chk_* outputs stable while chk_valid_o && !chk_ready_i.
REQ-024 SHALL have latency one cycle: a commit accepted at edge N into an empty system in RUN gives chk_valid_o=1 after edge N+1.
REQ-025 SHALL sustain one record per cycle when chk_ready_i is held high and any FIFO is non-empty.
REQ-026 SHALL set chk_seq_o to the count of completed handshakes before this record; the count increments by 1 per handshake and wraps modulo 2^64.
REQ-027 SHALL preserve per-core program order; the order between cores is set only by the arbitration rule.
REQ-028 SHALL treat simultaneous push and pop on a non-full FIFO as count unchanged, with both operations taking effect.

Reset
REQ-029 SHALL on rst clear every FIFO pointer and count, set FSM=IDLE, arbitration pointer=0, and sequence counter=0.
REQ-030 SHALL on rst drive chk_valid_o=0, chk_core_o=0, chk_pc_o=0, chk_insn_o=0, chk_seq_o=0, overflow_o=0, and commit_ready_o=all ones.
REQ-031 SHALL on rst asserted mid-operation discard all buffered and in-flight records with no further handshake; chk_valid_o falls asynchronously.

Verification
REQ-032 SHALL cover: NUM_CORES=1, arm_i=1, one commit pc=0x80000000 insn=0x00000013, chk_ready_i=1 -> one record with chk_seq_o=0 one cycle later.
REQ-033 SHALL cover: arm_i=0, core0 commits 5 times with DEPTH=4 -> 4 buffered, commit_ready_o[0]=0, overflow_o[0]=1; after arm_i=1, 4 records in order.
REQ-034 SHALL cover: NUM_CORES=4, all cores commit every cycle, chk_ready_i=1 -> core order 0,1,2,3,0,... and chk_seq_o 0,1,2,3,4,...
REQ-035 SHALL cover: chk_ready_i=0 for 10 cycles with a record valid -> payload stable, then exactly one handshake when chk_ready_i=1.
REQ-036 SHALL cover: arm_i falls with 3 buffered and 1 presented -> only the presented record completes, FSM reaches IDLE, 3 remain buffered.
REQ-037 SHALL cover: rst pulsed while chk_valid_o=1 and FIFOs non-empty -> chk_valid_o=0 immediately and all outputs at reset values.

Source files
------------

// File: rtl/cosim_commit_streamer.sv
// Merges per-core retire streams into one ordered record stream for the lock-step checker.
// State | meaning: IDLE = model not started | RUN = arbitrating FIFOs into the output register | DRAIN = finishing the presented record only
module cosim_commit_streamer #(
  parameter int NUM_CORES = 1,
  parameter int DEPTH     = 4,
  parameter int CW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm_i,
  input  logic [NUM_CORES-1:0]    commit_valid_i,
  input  logic [NUM_CORES*64-1:0] commit_pc_i,
  input  logic [NUM_CORES*32-1:0] commit_insn_i,
  output logic [NUM_CORES-1:0]    commit_ready_o,
  output logic                    chk_valid_o,
  input  logic                    chk_ready_i,
  output logic [CW-1:0]           chk_core_o,
  output logic [63:0]             chk_pc_o,
  output logic [31:0]             chk_insn_o,
  output logic [63:0]             chk_seq_o,
  output logic [NUM_CORES-1:0]    overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
  state_t state;

  logic [63:0]   pc_mem   [NUM_CORES][DEPTH];
  logic [31:0]   insn_mem [NUM_CORES][DEPTH];
  logic [AW-1:0] wr_ptr   [NUM_CORES];
  logic [AW-1:0] rd_ptr   [NUM_CORES];
  logic [AW:0]   count    [NUM_CORES];

  logic [NUM_CORES-1:0] push, pop, non_empty;
  logic [CW-1:0]        rr_ptr, grant, grant_next;
  logic                 grant_found, handshake, load;
  logic [63:0]          seq_cnt;

  // Ready looks only at the registered count, so a full FIFO never accepts on a pop cycle.
  for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
    assign commit_ready_o[k] = (count[k] != FULL);
    assign non_empty[k]      = (count[k] != '0);
    assign push[k]           = commit_valid_i[k] && commit_ready_o[k];
    assign pop[k]            = load && (grant == CW'(k));
  end

  always_comb begin
    logic [CW-1:0] idx;
    idx         = '0;
    grant       = '0;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = CW'((int'(rr_ptr) + i) % NUM_CORES);
      if (!grant_found && non_empty[idx]) begin
        grant_found = 1'b1;
        grant       = idx;
      end
    end
  end

  assign grant_next = CW'((int'(grant) + 1) % NUM_CORES);
  assign handshake  = chk_valid_o && chk_ready_i;
  assign load       = (state == ST_RUN) && (!chk_valid_o || chk_ready_i) && grant_found;
  assign chk_seq_o  = seq_cnt;

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CORES; k++) begin
      if (push[k]) begin
        pc_mem[k][wr_ptr[k]]   <= commit_pc_i[64*k +: 64];
        insn_mem[k][wr_ptr[k]] <= commit_insn_i[32*k +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
      overflow_o <= '0;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + 1'b1;
          2'b01:   count[k] <= count[k] - 1'b1;
          default: count[k] <= count[k];
        endcase
        if (commit_valid_i[k] && !commit_ready_o[k]) overflow_o[k] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      chk_valid_o <= 1'b0;
      chk_core_o  <= '0;
      chk_pc_o    <= '0;
      chk_insn_o  <= '0;
      rr_ptr      <= '0;
      seq_cnt     <= '0;
    end else begin
      if (handshake) seq_cnt <= seq_cnt + 64'd1;
      if (load) begin
        chk_valid_o <= 1'b1;
        chk_core_o  <= grant;
        chk_pc_o    <= pc_mem[grant][rd_ptr[grant]];
        chk_insn_o  <= insn_mem[grant][rd_ptr[grant]];
        rr_ptr      <= grant_next;
      end else if (handshake) begin
        chk_valid_o <= 1'b0;
      end
      case (state)
        ST_IDLE:  if (arm_i) state <= ST_RUN;
        ST_RUN:   if (!arm_i) state <= ST_DRAIN;
        ST_DRAIN: if (!chk_valid_o) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
